ibus_ram_arbiter: RTL and testbench
===================================

Name: ibus_ram_arbiter

Overview:
- Two-master arbiter for the on-chip CPU RAM slave port on the internal bus.
- Master 0 is the CPU core's IBUS; master 1 is the DMAC IBUS.
- Parks the RAM port on the last owner so the owner sees zero added latency.
- Stalls the non-owner via BUSY and re-arbitrates only at access boundaries, qualified by CE_R.
- Default policy is fixed priority (DMAC first) with a starvation limit for the CPU.

Parameters:
- SEL_NIB, 4'hF: value of A[27:24] that selects the RAM.
- MAX_WAIT, 4: consecutive stalled CE_R cycles of master 0 before it is forced to win; range 1..15.

Ports:
- CLK  in  1: system clock.
- RST_N  in  1: reset; asynchronous, active-low.
- CE_R  in  1: rising-phase clock enable. All state updates are qualified by it.
- M0_A / M1_A  in  28: master address.
- M0_DI / M1_DI  in  32: master write data.
- M0_BA / M1_BA  in  4: byte enables.
- M0_WE / M1_WE  in  1: write strobe.
- M0_REQ / M1_REQ  in  1: access request.
- M0_DO / M1_DO  out  32: read data, equal to S_DO for both masters.
- M0_BUSY / M1_BUSY  out  1: stall to the master.
- M0_ACT / M1_ACT  out  1: RAM claims this master's address.
- S_A  out  28: slave address.
- S_DI  out  32: slave write data.
- S_BA  out  4: slave byte enables.
- S_WE  out  1: slave write strobe.
- S_REQ  out  1: slave request.
- S_DO  in  32: RAM read data.
- S_BUSY  in  1: RAM stall.
- GRANT  out  2: registered owner, one-hot: bit0 = M0, bit1 = M1.

Behaviour:
- Decode:
  - hit_i = (Mi_A[27:24] == SEL_NIB).
  - sel_i = Mi_REQ & hit_i.
  - Mi_ACT = hit_i, combinational and independent of REQ and ownership.
- State:
  - OWN is a 1-bit register for the owner; it always points at one master, which parks the bus.
  - WCNT is a 4-bit starvation counter.
  - Async reset: OWN=0 (M0), WCNT=0, GRANT=2'b01.
- Slave mux (combinational, from OWN):
  - S_A, S_DI and S_BA come from the owner.
  - S_REQ = sel_own.
  - S_WE = own_WE & sel_own.
  - A non-owner can never write the RAM.
- Stall rules:
  - Owner BUSY = S_BUSY & sel_own.
  - Non-owner BUSY = sel_other, so it stays high until ownership transfers.
  - A master with REQ=0 or hit=0 sees BUSY=0.
- Access boundary: done = ~sel_own | ~S_BUSY. This is evaluated on the CLK rising edge with CE_R=1; with CE_R=0 nothing changes.
- Arbitration at done with CE_R=1:
  - Only the other master selecting: OWN <= other.
  - Neither selecting, or only the owner: OWN holds.
  - Both selecting, OWN=M0: OWN <= M1, unless WCNT was just reset by a forced M0 grant. In that case M0 keeps exactly one access.
  - Both selecting, OWN=M1: OWN <= M0 only if WCNT >= MAX_WAIT; otherwise M1 keeps it.
- Latency:
  - Owner: 0 added cycles.
  - Non-owner: at least 1 CE_R cycle, since it is granted at the edge that completes the owner's access and proceeds in the next CE_R cycle.
- WCNT:
  - Increments on CE_R when sel_0 & OWN=M1.
  - Saturates at 15.
  - Clears on CE_R when OWN=M0 or ~sel_0.
- GRANT is updated with OWN.
- Reset mid-access:
  - OWN returns to M0 immediately.
  - If M1 was writing, S_WE drops asynchronously; no partial handoff state survives.
- Simultaneous events:
  - Both masters asserting REQ in the same cycle while parked on M0: M0's access proceeds first, because it is the owner. M1 wins the next boundary.
  - S_BUSY high holds OWN regardless of other requests.

Optional Feature:
- RAMARB_RR_EN defined:
  - Both-selecting case always alternates: OWN <= other at every done.
  - WCNT is removed and MAX_WAIT is ignored.
- Undefined: fixed priority with starvation limit, as above.

Test Plan:
- Reset, then M0 reads 0xF000010, S_BUSY=0 → M0_BUSY=0 in the same cycle, S_A=M0_A, GRANT=01.
- Parked M0; M1 writes 0xF000020, BA=4'hF, data 0xDEADBEEF → M1_BUSY=1 for 1 CE_R cycle; next cycle S_WE=1, S_DI=0xDEADBEEF, GRANT=10.
- M1 continuous back-to-back requests, M0 requesting, MAX_WAIT=4 → M0 granted after the 4th stalled CE_R. M0 completes one access, then GRANT returns to 10.
- S_BUSY held high 3 cycles during an M0 access while M1 requests → OWN stays M0 for all 3, M1_BUSY=1; switch happens at the edge where S_BUSY=0.
- M1 request to 0xA000000 (hit=0) → M1_ACT=0, M1_BUSY=0, S_REQ unaffected, GRANT unchanged.
- RAMARB_RR_EN defined, both masters requesting continuously → GRANT alternates 01, 10, 01, 10 on each completed access; RST_N pulsed low mid-M1 write → S_WE=0 immediately, GRANT=01.

Source files
------------

// File: rtl/ibus_ram_arbiter_if.sv
// Bus bundle between the two IBUS masters, the RAM slave port and the arbiter.
// The slave modport is the arbiter's view; the master modport drives masters and RAM.
interface ibus_ram_arbiter_if;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    logic [AW-1:0] m0_a;
    logic [DW-1:0] m0_di;
    logic [BW-1:0] m0_ba;
    logic          m0_we;
    logic          m0_req;
    logic [DW-1:0] m0_do;
    logic          m0_busy;
    logic          m0_act;

    logic [AW-1:0] m1_a;
    logic [DW-1:0] m1_di;
    logic [BW-1:0] m1_ba;
    logic          m1_we;
    logic          m1_req;
    logic [DW-1:0] m1_do;
    logic          m1_busy;
    logic          m1_act;

    logic [AW-1:0] s_a;
    logic [DW-1:0] s_di;
    logic [BW-1:0] s_ba;
    logic          s_we;
    logic          s_req;
    logic [DW-1:0] s_do;
    logic          s_busy;

    modport slave (
        input  m0_a, m0_di, m0_ba, m0_we, m0_req,
        input  m1_a, m1_di, m1_ba, m1_we, m1_req,
        output m0_do, m0_busy, m0_act,
        output m1_do, m1_busy, m1_act,
        output s_a, s_di, s_ba, s_we, s_req,
        input  s_do, s_busy
    );

    modport master (
        output m0_a, m0_di, m0_ba, m0_we, m0_req,
        output m1_a, m1_di, m1_ba, m1_we, m1_req,
        input  m0_do, m0_busy, m0_act,
        input  m1_do, m1_busy, m1_act,
        input  s_a, s_di, s_ba, s_we, s_req,
        output s_do, s_busy
    );
endinterface

// File: rtl/ibus_ram_arbiter.sv
// Two-master (CPU, DMAC) arbiter for the CPU RAM port, parking on the last owner.
// RAMARB_RR_EN selects round-robin instead of DMAC-first priority with a CPU starvation limit.
module ibus_ram_arbiter #(
    parameter logic [3:0]  SEL_NIB  = 4'hF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce_r,
    ibus_ram_arbiter_if.slave   bus,
    output logic [1:0]          grant
);
    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } own_t;

    own_t       own_q;
    own_t       own_d;
    own_t       own_oth;
    logic [1:0] grant_q;
    logic       hit0;
    logic       hit1;
    logic       sel0;
    logic       sel1;
    logic       sel_own;
    logic       sel_oth;
    logic       done;

    // Address decode; ACT ignores REQ and ownership
    assign hit0 = (bus.m0_a[27:24] == SEL_NIB);
    assign hit1 = (bus.m1_a[27:24] == SEL_NIB);
    assign sel0 = bus.m0_req & hit0;
    assign sel1 = bus.m1_req & hit1;
    assign bus.m0_act = hit0;
    assign bus.m1_act = hit1;

    assign own_oth = (own_q == OWN_M0) ? OWN_M1 : OWN_M0;
    assign sel_own = (own_q == OWN_M0) ? sel0 : sel1;
    assign sel_oth = (own_q == OWN_M0) ? sel1 : sel0;
    assign done    = ~sel_own | ~bus.s_busy;

    // Slave port follows the owner; a non-owner never reaches the RAM write strobe
    assign bus.s_a   = (own_q == OWN_M0) ? bus.m0_a  : bus.m1_a;
    assign bus.s_di  = (own_q == OWN_M0) ? bus.m0_di : bus.m1_di;
    assign bus.s_ba  = (own_q == OWN_M0) ? bus.m0_ba : bus.m1_ba;
    assign bus.s_req = sel_own;
    assign bus.s_we  = ((own_q == OWN_M0) ? bus.m0_we : bus.m1_we) & sel_own;

    assign bus.m0_do = bus.s_do;
    assign bus.m1_do = bus.s_do;

    // Owner stalls on RAM busy; non-owner stalls until the handoff
    assign bus.m0_busy = (own_q == OWN_M0) ? (bus.s_busy & sel0) : sel0;
    assign bus.m1_busy = (own_q == OWN_M1) ? (bus.s_busy & sel1) : sel1;

    assign grant = grant_q;

`ifdef RAMARB_RR_EN
    always_comb begin
        own_d = own_q;
        if (done && sel_oth) begin
            own_d = own_oth;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q   <= OWN_M0;
            grant_q <= 2'b01;
        end else if (ce_r) begin
            own_q   <= own_d;
            grant_q <= (own_d == OWN_M1) ? 2'b10 : 2'b01;
        end
    end
`else
    logic [3:0] wcnt_q;
    logic [3:0] wcnt_d;

    // DMAC wins contention unless the CPU has waited MAX_WAIT cycles; a forced
    // CPU grant clears WCNT, so the CPU keeps the port for exactly one access
    always_comb begin
        own_d  = own_q;
        wcnt_d = 4'd0;
        if (done && sel_oth) begin
            if (!sel_own) begin
                own_d = own_oth;
            end else if (own_q == OWN_M0) begin
                own_d = OWN_M1;
            end else if (wcnt_q >= 4'(MAX_WAIT)) begin
                own_d = OWN_M0;
            end
        end
        if ((own_q == OWN_M1) && sel0) begin
            wcnt_d = (wcnt_q == 4'hF) ? wcnt_q : wcnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q   <= OWN_M0;
            wcnt_q  <= 4'd0;
            grant_q <= 2'b01;
        end else if (ce_r) begin
            own_q   <= own_d;
            wcnt_q  <= wcnt_d;
            grant_q <= (own_d == OWN_M1) ? 2'b10 : 2'b01;
        end
    end
`endif
endmodule

// File: tb/tb_ibus_ram_arbiter.sv
// Directed self-checking bench for ibus_ram_arbiter; builds with or without RAMARB_RR_EN.
module tb_ibus_ram_arbiter;
    localparam int unsigned MAX_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce_r;
    logic [1:0] grant;
    logic [1:0] exp_seq [8];
    int         n_checks = 0;
    int         n_errors = 0;

    ibus_ram_arbiter_if bus ();

    ibus_ram_arbiter #(
        .SEL_NIB  (4'hF),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_r  (ce_r),
        .bus   (bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [27:0] a,
                          input logic [31:0] di, input logic [3:0] ba);
        bus.m0_req = req;
        bus.m0_we  = we;
        bus.m0_a   = a;
        bus.m0_di  = di;
        bus.m0_ba  = ba;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [27:0] a,
                          input logic [31:0] di, input logic [3:0] ba);
        bus.m1_req = req;
        bus.m1_we  = we;
        bus.m1_a   = a;
        bus.m1_di  = di;
        bus.m1_ba  = ba;
    endtask

    initial begin
`ifdef RAMARB_RR_EN
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
        exp_seq[4] = 2'b10; exp_seq[5] = 2'b01; exp_seq[6] = 2'b10; exp_seq[7] = 2'b01;
`else
        // M1 holds through WCNT 0..3, forced M0 grant at WCNT=4, M0 gets one access
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10; exp_seq[3] = 2'b10;
        exp_seq[4] = 2'b10; exp_seq[5] = 2'b01; exp_seq[6] = 2'b10; exp_seq[7] = 2'b10;
`endif
        rst_n = 1'b0;
        ce_r  = 1'b1;
        set_m0(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
        bus.s_do   = 32'h0;
        bus.s_busy = 1'b0;
        #12;
        check("rst_grant", 32'(grant), 32'h1);
        check("rst_s_we", 32'(bus.s_we), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Parked M0 read: zero added latency
        set_m0(1'b1, 1'b0, 28'hF000010, 32'h0, 4'hF);
        bus.s_do = 32'h12345678;
        settle();
        check("m0_rd_busy", 32'(bus.m0_busy), 32'h0);
        check("m0_rd_s_a", 32'(bus.s_a), 32'hF000010);
        check("m0_rd_s_req", 32'(bus.s_req), 32'h1);
        check("m0_rd_act", 32'(bus.m0_act), 32'h1);
        check("m0_do", bus.m0_do, 32'h12345678);
        check("m1_do", bus.m1_do, 32'h12345678);
        check("m0_rd_grant", 32'(grant), 32'h1);
        step();
        check("m0_rd_grant_hold", 32'(grant), 32'h1);

        // M1 write while parked on M0: one stall cycle, then the write reaches the RAM
        set_m0(1'b0, 1'b0, 28'hF000010, 32'h0, 4'hF);
        set_m1(1'b1, 1'b1, 28'hF000020, 32'hDEADBEEF, 4'hF);
        settle();
        check("m1_wr_busy", 32'(bus.m1_busy), 32'h1);
        check("m1_wr_no_we", 32'(bus.s_we), 32'h0);
        check("m1_wr_no_req", 32'(bus.s_req), 32'h0);
        step();
        check("m1_wr_grant", 32'(grant), 32'h2);
        check("m1_wr_busy2", 32'(bus.m1_busy), 32'h0);
        check("m1_wr_s_we", 32'(bus.s_we), 32'h1);
        check("m1_wr_s_di", bus.s_di, 32'hDEADBEEF);
        check("m1_wr_s_a", 32'(bus.s_a), 32'hF000020);
        check("m1_wr_s_ba", 32'(bus.s_ba), 32'hF);

`ifndef RAMARB_RR_EN
        // Starvation limit: M1 back-to-back, M0 waiting
        set_m0(1'b1, 1'b0, 28'hF000030, 32'h0, 4'hF);
        set_m1(1'b1, 1'b0, 28'hF000040, 32'h0, 4'hF);
        for (int i = 0; i <= int'(MAX_WAIT); i++) begin
            settle();
            check("starve_m0_busy", 32'(bus.m0_busy), 32'h1);
            check("starve_s_a", 32'(bus.s_a), 32'hF000040);
            step();
            check("starve_grant", 32'(grant), (i >= int'(MAX_WAIT)) ? 32'h1 : 32'h2);
        end
        settle();
        check("forced_m0_busy", 32'(bus.m0_busy), 32'h0);
        check("forced_m1_busy", 32'(bus.m1_busy), 32'h1);
        check("forced_s_a", 32'(bus.s_a), 32'hF000030);
        step();
        check("forced_one_access", 32'(grant), 32'h2);
`endif

        // CE_R low freezes ownership
        set_m0(1'b1, 1'b0, 28'hF000030, 32'h0, 4'hF);
        set_m1(1'b0, 1'b0, 28'hF000040, 32'h0, 4'hF);
        ce_r = 1'b0;
        step();
        check("ce_hold_grant", 32'(grant), 32'h2);
        check("ce_hold_m0_busy", 32'(bus.m0_busy), 32'h1);
        ce_r = 1'b1;
        step();
        check("ce_handoff_grant", 32'(grant), 32'h1);

        // S_BUSY holds the owner for 3 cycles, then the handoff happens
        bus.s_busy = 1'b1;
        set_m1(1'b1, 1'b0, 28'hF000050, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("sbusy_m0_busy", 32'(bus.m0_busy), 32'h1);
            check("sbusy_m1_busy", 32'(bus.m1_busy), 32'h1);
            check("sbusy_s_a", 32'(bus.s_a), 32'hF000030);
            step();
            check("sbusy_grant", 32'(grant), 32'h1);
        end
        bus.s_busy = 1'b0;
        settle();
        check("sbusy_release_busy", 32'(bus.m0_busy), 32'h0);
        step();
        check("sbusy_switch_grant", 32'(grant), 32'h2);

        // Miss address: no claim, no stall, no slave request
        set_m0(1'b0, 1'b0, 28'hF000030, 32'h0, 4'hF);
        set_m1(1'b1, 1'b0, 28'hA000000, 32'h0, 4'hF);
        settle();
        check("miss_m1_act", 32'(bus.m1_act), 32'h0);
        check("miss_m1_busy", 32'(bus.m1_busy), 32'h0);
        check("miss_s_req", 32'(bus.s_req), 32'h0);
        step();
        check("miss_grant", 32'(grant), 32'h2);
        set_m1(1'b0, 1'b0, 28'hF000070, 32'h0, 4'hF);
        settle();
        check("act_no_req", 32'(bus.m1_act), 32'h1);

        // Reset in the middle of an M1 write
        set_m1(1'b1, 1'b1, 28'hF000060, 32'hCAFEF00D, 4'h3);
        settle();
        check("pre_rst_s_we", 32'(bus.s_we), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_we", 32'(bus.s_we), 32'h0);
        check("mid_rst_grant", 32'(grant), 32'h1);
        set_m1(1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Both masters requesting continuously from a fresh park on M0
        set_m0(1'b1, 1'b0, 28'hF000100, 32'h0, 4'hF);
        set_m1(1'b1, 1'b0, 28'hF000200, 32'h0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            step();
            check("both_seq_grant", 32'(grant), 32'(exp_seq[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
